// File: rtl/get_snoop_result.sv
// Snoop responder modelling the other caches on the shared bus: 'R'/'M' requests get HIT/HITM/NOHIT from addr[1:0].
// One-cycle registered latency, no back-pressure; statistics counters exist only when SNOOP_STATS_EN is defined.
module get_snoop_result #(
    parameter int lineSize    = 512,
    parameter int addressSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [lineSize-1:0] sharedBus,
    input  logic [7:0]          sharedOperationBus,
    output logic [1:0]          snoopBus,
    output logic                snoopValid,
    output logic [31:0]         hitCount,
    output logic [31:0]         hitmCount,
    output logic [31:0]         nohitCount,
    output logic [31:0]         illegalOpCount
);
    localparam logic [7:0] OP_IDLE  = 8'h00;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_RWIM  = 8'h4D;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_INVAL = 8'h49;

    localparam logic [1:0] SNP_HIT   = 2'b00;
    localparam logic [1:0] SNP_HITM  = 2'b01;
    localparam logic [1:0] SNP_NOHIT = 2'b10;
    localparam logic [1:0] SNP_NONE  = 2'b11;

    logic [1:0] snoop_d, snoop_q;
    logic       valid_d, valid_q;

    // Only the two lowest address bits decide the result.
    logic unused_bits;
    assign unused_bits = ^{sharedBus[lineSize-1:addressSize], sharedBus[addressSize-1:2]};

    always_comb begin
        snoop_d = SNP_NONE;
        valid_d = 1'b0;
        if (sharedOperationBus == OP_READ || sharedOperationBus == OP_RWIM) begin
            valid_d = 1'b1;
            case (sharedBus[1:0])
                2'b00:   snoop_d = SNP_HIT;
                2'b01:   snoop_d = SNP_HITM;
                default: snoop_d = SNP_NOHIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snoop_q <= SNP_NONE;
            valid_q <= 1'b0;
        end else begin
            snoop_q <= snoop_d;
            valid_q <= valid_d;
        end
    end

    assign snoopBus   = snoop_q;
    assign snoopValid = valid_q;

`ifdef SNOOP_STATS_EN
    logic [31:0] hit_q, hitm_q, nohit_q, illegal_q;
    logic        illegal_d;

    always_comb begin
        illegal_d = 1'b1;
        case (sharedOperationBus)
            OP_IDLE, OP_READ, OP_RWIM, OP_WRITE, OP_INVAL: illegal_d = 1'b0;
            default:                                       illegal_d = 1'b1;
        endcase
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q     <= '0;
            hitm_q    <= '0;
            nohit_q   <= '0;
            illegal_q <= '0;
        end else begin
            if (valid_d && snoop_d == SNP_HIT && hit_q != '1)
                hit_q <= hit_q + 32'd1;
            if (valid_d && snoop_d == SNP_HITM && hitm_q != '1)
                hitm_q <= hitm_q + 32'd1;
            if (valid_d && snoop_d == SNP_NOHIT && nohit_q != '1)
                nohit_q <= nohit_q + 32'd1;
            if (illegal_d && illegal_q != '1)
                illegal_q <= illegal_q + 32'd1;
        end
    end

    assign hitCount       = hit_q;
    assign hitmCount      = hitm_q;
    assign nohitCount     = nohit_q;
    assign illegalOpCount = illegal_q;
`else
    assign hitCount       = 32'd0;
    assign hitmCount      = 32'd0;
    assign nohitCount     = 32'd0;
    assign illegalOpCount = 32'd0;
`endif

endmodule

// File: tb/tb_get_snoop_result.sv
// Directed bench for get_snoop_result: expected responses queued at drive time, popped one edge later.
// Counter expectations follow SNOOP_STATS_EN (zero when undefined).
module tb_get_snoop_result;
    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] sharedBus;
    logic [7:0]   sharedOperationBus;
    logic [1:0]   snoopBus;
    logic         snoopValid;
    logic [31:0]  hitCount, hitmCount, nohitCount, illegalOpCount;

    int total = 0;
    int bad   = 0;

    logic [2:0]  exp_q[$];
    logic [31:0] e_hit, e_hitm, e_nohit, e_ill;

    always #5 clk = ~clk;

    get_snoop_result #(.lineSize(512), .addressSize(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .sharedBus         (sharedBus),
        .sharedOperationBus(sharedOperationBus),
        .snoopBus          (snoopBus),
        .snoopValid        (snoopValid),
        .hitCount          (hitCount),
        .hitmCount         (hitmCount),
        .nohitCount        (nohitCount),
        .illegalOpCount    (illegalOpCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {valid, result} expected for an op/address pair.
    function automatic logic [2:0] model(input logic [7:0] op, input logic [1:0] a);
        if (op == 8'h52 || op == 8'h4D) begin
            if (a == 2'b00)      return 3'b100;
            else if (a == 2'b01) return 3'b101;
            else                 return 3'b110;
        end
        return 3'b011;
    endfunction

    task automatic step(input string tag, input logic rst, input logic [7:0] op,
                        input logic [511:0] bus);
        logic [2:0] e;
        logic [2:0] r;
        @(negedge clk);
        reset              = rst;
        sharedOperationBus = op;
        sharedBus          = bus;
        e = rst ? 3'b011 : model(op, bus[1:0]);
        exp_q.push_back(e);
`ifdef SNOOP_STATS_EN
        if (rst) begin
            e_hit = 0; e_hitm = 0; e_nohit = 0; e_ill = 0;
        end else begin
            if (e == 3'b100) e_hit++;
            if (e == 3'b101) e_hitm++;
            if (e == 3'b110) e_nohit++;
            if (!(op inside {8'h00, 8'h52, 8'h4D, 8'h57, 8'h49})) e_ill++;
        end
`endif
        @(posedge clk);
        #1;
        r = exp_q.pop_front();
        chk({tag, ".bus"},   {30'd0, snoopBus}, {30'd0, r[1:0]});
        chk({tag, ".vld"},   {31'd0, snoopValid}, {31'd0, r[2]});
        chk({tag, ".hit"},   hitCount, e_hit);
        chk({tag, ".hitm"},  hitmCount, e_hitm);
        chk({tag, ".nohit"}, nohitCount, e_nohit);
        chk({tag, ".ill"},   illegalOpCount, e_ill);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        e_hit = 0; e_hitm = 0; e_nohit = 0; e_ill = 0;
        reset = 1'b1;
        sharedOperationBus = 8'h00;
        sharedBus = '0;

        step("rst0", 1'b1, 8'h00, 512'h0);
        step("rst1", 1'b1, 8'h00, 512'h0);
        step("idle", 1'b0, 8'h00, 512'h0);

        step("dec0", 1'b0, 8'h52, 512'h1000);
        step("dec1", 1'b0, 8'h52, 512'h1001);
        step("dec2", 1'b0, 8'h52, 512'h1002);
        step("dec3", 1'b0, 8'h52, 512'h1003);
        step("drop", 1'b0, 8'h00, 512'h0);

        step("wr",   1'b0, 8'h57, 512'hFFFF_FFC1);
        step("inv",  1'b0, 8'h49, 512'h0);

        step("ill",  1'b0, 8'h58, 512'h1000);
        step("rwim", 1'b0, 8'h4D, {{480{1'b1}}, 32'h8000_0001});
        step("rwim0", 1'b0, 8'h4D, {{480{1'b1}}, 32'hFFFF_FFFC});
        step("hold0", 1'b0, 8'h52, 512'h2);
        step("hold1", 1'b0, 8'h52, 512'h2);

        step("rprio", 1'b1, 8'h52, 512'h0);
        step("post", 1'b0, 8'h00, 512'h0);
        step("rd",   1'b0, 8'h52, 512'h5);
        step("rclr", 1'b1, 8'h00, 512'h0);
        step("end",  1'b0, 8'h00, 512'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
